// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: operation codes, controller states
// and the signedness decode.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL   = 4'd0,
        OP_MULU  = 4'd1,
        OP_MAD   = 4'd2,
        OP_MADU  = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MSUBU = 4'd5,
        OP_DIV   = 4'd6,
        OP_DIVU  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    // Even codes are the signed variants of each arithmetic pair.
    function automatic logic is_signed(input op_t o);
        logic [3:0] code;
        code = o;
        return ~code[0];
    endfunction

endpackage

// File: rtl/muldiv_sdiv_core.sv
// Unsigned W-bit restoring divider: one quotient bit per cycle, W cycles per divide.
// Operates on magnitudes only; sign handling lives in the parent.
module sdiv_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clear,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         last_step,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [2*W-1:0] rq;
    logic [W-1:0]   dvs;
    logic [W-1:0]   cnt;
    logic [W:0]     partial;
    logic [W:0]     trial;

    // Partial remainder shifted left with the next dividend bit; needs W+1 bits.
    always_comb begin
        partial = rq[2*W-1:W-1];
        trial   = partial - {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq   <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (clear) begin
            rq   <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rq   <= {{W{1'b0}}, dividend};
            dvs  <= divisor;
            cnt  <= W'(W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (trial[W])
                rq <= {partial[W-1:0], rq[W-2:0], 1'b0};
            else
                rq <= {trial[W-1:0], rq[W-2:0], 1'b1};
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign last_step = busy && (cnt == '0);
    assign quotient  = rq[W-1:0];
    assign remainder = rq[2*W-1:W];

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the HI/LO pair; mul-class ops take one busy cycle, divides W+1.
// Define MULDIV_MSUB_EN to implement MSUB/MSUBU; otherwise OP 4/5 are no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  op_t          op,
    input  logic         kill,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done
);

    state_t         state, state_next;
    op_t            op_q;
    logic [2*W-1:0] prod_q, acc, acc_sum, a_ext, b_ext;
    logic           accept, do_mul, do_div, sgn;
    logic           q_neg, r_neg, zero_div;
    logic [W-1:0]   a_hold, a_mag, b_mag;
    logic [W-1:0]   div_q, div_r, quo_fix, rem_fix;
    logic           div_busy, div_last, div_clear;

    always_comb begin
        accept = en && !kill && (state == ST_IDLE);
        do_mul = 1'b0;
        do_div = 1'b0;
        case (op)
            OP_MUL, OP_MULU, OP_MAD, OP_MADU: do_mul = 1'b1;
`ifdef MULDIV_MSUB_EN
            OP_MSUB, OP_MSUBU:                do_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:                  do_div = 1'b1;
            default: ;
        endcase
        sgn   = is_signed(op);
        a_ext = {{W{sgn & a[W-1]}}, a};
        b_ext = {{W{sgn & b[W-1]}}, b};
        a_mag = (sgn && a[W-1]) ? -a : a;
        b_mag = (sgn && b[W-1]) ? -b : b;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && do_mul)
                    state_next = ST_MUL;
                else if (accept && do_div)
                    state_next = ST_DIV;
            end
            ST_MUL: state_next = ST_IDLE;
            ST_DIV: if (div_last || !div_busy) state_next = ST_FIX;
            ST_FIX: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (kill && state != ST_IDLE)
            state_next = ST_IDLE;
        div_clear = kill && (state != ST_IDLE);
    end

    always_comb begin
        acc = {hi, lo};
        case (op_q)
            OP_MAD, OP_MADU:   acc_sum = acc + prod_q;
`ifdef MULDIV_MSUB_EN
            OP_MSUB, OP_MSUBU: acc_sum = acc - prod_q;
`endif
            default:           acc_sum = prod_q;
        endcase
        quo_fix = q_neg ? -div_q : div_q;
        rem_fix = r_neg ? -div_r : div_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= ((state == ST_MUL) || (state == ST_FIX)) && !kill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            prod_q   <= '0;
            op_q     <= OP_MUL;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_div <= 1'b0;
            a_hold   <= '0;
        end else begin
            if (accept && op == OP_MTHI)
                hi <= a;
            if (accept && op == OP_MTLO)
                lo <= a;
            if (accept && do_mul) begin
                prod_q <= a_ext * b_ext;
                op_q   <= op;
            end
            if (accept && do_div) begin
                q_neg    <= sgn & (a[W-1] ^ b[W-1]);
                r_neg    <= sgn & a[W-1];
                zero_div <= (b == '0);
                a_hold   <= a;
            end
            if (!kill && state == ST_MUL)
                {hi, lo} <= acc_sum;
            // Division by zero bypasses the fixup so HI returns the raw dividend.
            if (!kill && state == ST_FIX) begin
                if (zero_div)
                    {hi, lo} <= {a_hold, {W{1'b1}}};
                else
                    {hi, lo} <= {rem_fix, quo_fix};
            end
        end
    end

    sdiv_core #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && do_div),
        .clear     (div_clear),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .last_step (div_last),
        .quotient  (div_q),
        .remainder (div_r)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed test-plan cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int EV_NONE = 0;
    localparam int EV_EN   = 1;
    localparam int EV_KILL = 2;
    localparam int EV_RST  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         kill = 1'b0;
    op_t          op = OP_MUL;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .op   (op),
        .kill (kill),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_result", {hi, lo}, mon_exp);
            end
        end
    end

    // Reference: cls 0 = immediate/no-op, 1 = multiply class, 2 = divide.
    task automatic model(input int code, input logic [31:0] av, input logic [31:0] bv,
                         output int cls, output logic [63:0] res);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, acc;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        ua  = {32'b0, av};
        ub  = {32'b0, bv};
        acc = {m_hi, m_lo};
        res = acc;
        cls = 0;
        case (code)
            0: begin cls = 1; res = sa * sb; end
            1: begin cls = 1; res = ua * ub; end
            2: begin cls = 1; res = acc + sa * sb; end
            3: begin cls = 1; res = acc + ua * ub; end
`ifdef MULDIV_MSUB_EN
            4: begin cls = 1; res = acc - sa * sb; end
            5: begin cls = 1; res = acc - ua * ub; end
`endif
            6, 7: begin
                cls = 2;
                if (bv == 32'd0) begin
                    res = {av, 32'hffffffff};
                end else if (code == 6) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {ua % ub};
                    res = {res[31:0], 32'd0};
                    ua  = ua / ub;
                    res = {res[63:32], ua[31:0]};
                end
            end
            8: res = {av, m_lo};
            9: res = {m_hi, av};
            default: ;
        endcase
    endtask

    task automatic run_op(input int code, input logic [31:0] av, input logic [31:0] bv,
                          input int evt, input int evt_at);
        int cls, cnt, exp_busy;
        logic [63:0] res;
        bit finished;
        model(code, av, bv, cls, res);
        exp_busy = (cls == 1) ? 1 : (cls == 2) ? W + 1 : 0;
        @(negedge clk);
        en = 1'b1;
        op = op_t'(code[3:0]);
        a  = av;
        b  = bv;
        if (evt != EV_KILL && evt != EV_RST) begin
            if (cls != 0) exp_q.push_back(res);
            m_hi = res[63:32];
            m_lo = res[31:0];
        end
        cnt = 0;
        finished = 1'b0;
        for (int guard = 0; guard < 200; guard++) begin
            @(negedge clk);
            en   = 1'b0;
            kill = 1'b0;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            cnt++;
            if (cnt == evt_at) begin
                if (evt == EV_EN) begin
                    en = 1'b1;
                    op = OP_MUL;
                    a  = $urandom;
                    b  = $urandom;
                end else if (evt == EV_KILL) begin
                    kill = 1'b1;
                end else if (evt == EV_RST) begin
                    rst = 1'b1;
                    #1;
                    check("reset_mid_hi", {32'b0, hi}, 64'd0);
                    check("reset_mid_lo", {32'b0, lo}, 64'd0);
                    check("reset_mid_busy", {63'b0, busy}, 64'd0);
                    m_hi = '0;
                    m_lo = '0;
                    #1 rst = 1'b0;
                end
            end
        end
        if (!finished) check("busy_timeout", {63'b0, busy}, 64'd0);
        check("busy_cycles", 64'(cnt), 64'((evt == EV_KILL || evt == EV_RST) ? evt_at : exp_busy));
        check("hilo_after_op", {hi, lo}, {m_hi, m_lo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffffffff;
            3: return 32'h80000000;
            4: return 32'h7fffffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        rst = 1'b0;

        run_op(0, 32'hfffffffd, 32'd7, EV_NONE, 0);
        check("tp_mul", {hi, lo}, 64'hffffffff_ffffffeb);
        run_op(8, 32'd0, 32'd0, EV_NONE, 0);
        run_op(9, 32'hffffffff, 32'd0, EV_NONE, 0);
        run_op(3, 32'd1, 32'd1, EV_NONE, 0);
        check("tp_madu", {hi, lo}, 64'h00000001_00000000);
        run_op(6, 32'hfffffff9, 32'd2, EV_NONE, 0);
        check("tp_div_neg", {hi, lo}, 64'hffffffff_fffffffd);
        run_op(6, 32'h80000000, 32'hffffffff, EV_NONE, 0);
        check("tp_div_ovf", {hi, lo}, 64'h00000000_80000000);
        run_op(7, 32'd5, 32'd0, EV_NONE, 0);
        check("tp_divu_zero", {hi, lo}, 64'h00000005_ffffffff);
        run_op(6, 32'hfffffffb, 32'd0, EV_NONE, 0);
        check("tp_div_zero", {hi, lo}, 64'hfffffffb_ffffffff);

        run_op(6, 32'd100, 32'd7, EV_EN, 10);
        run_op(7, 32'd1000, 32'd3, EV_KILL, 20);
        run_op(2, 32'd9, 32'd9, EV_KILL, 1);
        run_op(6, 32'd1234, 32'd5, EV_KILL, W + 1);
        run_op(6, 32'd1234, 32'd5, EV_RST, 5);
        check("tp_reset_mid", {hi, lo}, 64'd0);

        run_op(9, 32'd10, 32'd0, EV_NONE, 0);
        run_op(8, 32'd0, 32'd0, EV_NONE, 0);
        run_op(4, 32'd3, 32'd4, EV_NONE, 0);
`ifdef MULDIV_MSUB_EN
        check("tp_msub", {hi, lo}, 64'hffffffff_fffffffe);
`else
        check("tp_msub_off", {hi, lo}, 64'h00000000_0000000a);
`endif

        for (int c = 10; c < 16; c++) run_op(c, $urandom, $urandom, EV_NONE, 0);

        // EN together with KILL in IDLE must be dropped.
        @(negedge clk);
        en = 1'b1; kill = 1'b1; op = OP_MTHI; a = 32'h12345678;
        @(negedge clk);
        en = 1'b0; kill = 1'b0;
        check("kill_idle_hi", {32'b0, hi}, {32'b0, m_hi});
        @(negedge clk);
        en = 1'b1; kill = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd3;
        @(negedge clk);
        en = 1'b0; kill = 1'b0;
        check("kill_idle_busy", {63'b0, busy}, 64'd0);

        repeat (60) run_op(int'($urandom_range(0, 15)), pick(), pick(), EV_NONE, 0);
        repeat (4) run_op(6 + int'($urandom_range(0, 1)), pick(), pick(), EV_KILL,
                          int'($urandom_range(1, W + 1)));

        repeat (3) @(negedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
